stream_demux_1to4: RTL and testbench

Registered 1-to-4 stream demultiplexer: accepts one valid/ready input stream carrying a 2-bit destination select and steers each beat into one of four independently back-pressured output streams. Each output has its own one-entry holding register, so a stalled output blocks only beats destined for it. Per-output enables let software disable a destination; beats aimed at a disabled output are dropped and counted. It is the fan-out counterpart to the team's mux blocks and sits between a single producer and up to four consumers.

---
 rtl/demux_pkg.sv | 15 +
 rtl/stream_demux_1to4_if.sv | 23 ++
 rtl/demux_out_slot.sv | 37 +++
 rtl/stream_demux_1to4.sv | 51 +++++
 tb/tb_stream_demux_1to4.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
// sat_inc is width-generic so every counter in the block can use it.
package demux_pkg;
  localparam int N_OUT      = 4;
  localparam int SEL_W      = 2;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max;
    max = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/stream_demux_1to4_if.sv
// Input stream plus the four output streams of the demux.
// slave = the demux, master = producer/consumer side.
interface stream_demux_1to4_if import demux_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);
  logic                            in_valid;
  logic                            in_ready;
  logic [DATA_W-1:0]               in_data;
  logic [SEL_W-1:0]                in_sel;
  logic [N_OUT-1:0]                out_valid;
  logic [N_OUT-1:0]                out_ready;
  logic [N_OUT-1:0][DATA_W-1:0]    out_data;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_out_slot.sv
// One-entry output holding register with its delivered-beat counter.
// A fill wins over a drain in the same cycle, giving one beat/cycle throughput.
module demux_out_slot import demux_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  cnt
);
  logic drain;

  assign drain = valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      cnt   <= '0;
    end else begin
      // data only moves on a fill; it keeps the last beat while empty
      if (fill) begin
        valid <= 1'b1;
        data  <= fill_data;
      end else if (drain) begin
        valid <= 1'b0;
      end
      if (drain)
        cnt <= CNT_W'(sat_inc(32'(cnt), CNT_W));
    end
  end
endmodule

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream demux: steers each input beat to the slot named by in_sel,
// drops (and counts) beats whose destination is disabled.
module stream_demux_1to4 import demux_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  stream_demux_1to4_if.slave           bus,
  input  logic [N_OUT-1:0]             out_en,
  output logic [N_OUT-1:0][CNT_W-1:0]  deliv_cnt,
  output logic [CNT_W-1:0]             drop_cnt
);
  logic                         sel_en;
  logic                         rdy;
  logic                         accept;
  logic [N_OUT-1:0]             fill;
  logic [N_OUT-1:0]             valid_q;
  logic [N_OUT-1:0][DATA_W-1:0] data_q;

  // Disabled destinations always accept so their beats can be discarded.
  assign sel_en = out_en[bus.in_sel];
  assign rdy    = sel_en ? (!valid_q[bus.in_sel] || bus.out_ready[bus.in_sel]) : 1'b1;
  assign accept = bus.in_valid && rdy;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    assign fill[i] = accept && sel_en && (bus.in_sel == SEL_W'(i));

    demux_out_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .fill      (fill[i]),
      .fill_data (bus.in_data),
      .ready     (bus.out_ready[i]),
      .valid     (valid_q[i]),
      .data      (data_q[i]),
      .cnt       (deliv_cnt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (accept && !sel_en)
      drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
  end
endmodule

// File: tb/tb_stream_demux_1to4.sv
// Directed bench for stream_demux_1to4: driver pushes expected beats per output,
// a negedge monitor pops and compares every output handshake.
module tb_stream_demux_1to4;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] out_en;
  logic [3:0][7:0] deliv_cnt;
  logic [7:0] drop_cnt;

  stream_demux_1to4_if #(.DATA_W(8)) bus ();

  stream_demux_1to4 #(.DATA_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .out_en    (out_en),
    .deliv_cnt (deliv_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int exp_drop = 0;
  logic [7:0] exp_q [4][$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat; waited = cycles spent with in_ready low.
  task automatic send(input logic [1:0] s, input logic [7:0] d, output int waited);
    bus.in_valid = 1'b1;
    bus.in_sel   = s;
    bus.in_data  = d;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_total++;
      $display("FAIL send_timeout: sel %0d data %0h never accepted", s, d);
    end else if (out_en[s]) begin
      exp_q[s].push_back(d);
    end else begin
      exp_drop++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.out_valid[i] && bus.out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            n_total++;
            $display("FAIL out_unexpected: output %0d data %0h, want no beat", i, bus.out_data[i]);
          end else begin
            chk($sformatf("out_data[%0d]", i), 32'(bus.out_data[i]), 32'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    out_en = 4'hF;
    bus.in_valid = 1'b0;
    bus.in_sel = '0;
    bus.in_data = '0;
    bus.out_ready = 4'hF;
    step(); step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_deliv", 32'(deliv_cnt), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    rst = 1'b0;
    step();

    // single beat, latency and counter
    send(2'd2, 8'hA1, w);
    chk("t1_out_valid", 32'(bus.out_valid), 32'h4);
    chk("t1_out_data2", 32'(bus.out_data[2]), 32'hA1);
    step();
    chk("t1_deliv2", 32'(deliv_cnt[2]), 32'h1);
    chk("t1_out_valid_clr", 32'(bus.out_valid), 32'h0);

    // back-pressure on output 1, then drain+fill in one cycle
    bus.out_ready[1] = 1'b0;
    send(2'd1, 8'h11, w);
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'h22;
    #1;
    chk("t2_in_ready_blocked", 32'(bus.in_ready), 32'h0);
    step(); step();
    chk("t2_in_ready_still", 32'(bus.in_ready), 32'h0);
    chk("t2_held_data", 32'(bus.out_data[1]), 32'h11);
    bus.out_ready[1] = 1'b1;
    send(2'd1, 8'h22, w);
    chk("t2_wait", 32'(w), 32'h0);
    chk("t2_valid_kept", 32'(bus.out_valid[1]), 32'h1);
    chk("t2_refill", 32'(bus.out_data[1]), 32'h22);
    step();

    // stalled output 1 does not block other outputs
    bus.out_ready = 4'b1101;
    send(2'd1, 8'h40, w);
    send(2'd0, 8'h30, w); chk("t3_wait0", 32'(w), 32'h0);
    send(2'd3, 8'h31, w); chk("t3_wait1", 32'(w), 32'h0);
    send(2'd0, 8'h32, w); chk("t3_wait2", 32'(w), 32'h0);
    send(2'd3, 8'h33, w); chk("t3_wait3", 32'(w), 32'h0);
    step();
    chk("t3_slot1_held", 32'(bus.out_valid), 32'h2);
    bus.out_ready = 4'hF;
    step(); step();

    // disabled destination drops beats
    out_en = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      send(2'd1, 8'(8'h60 + k), w);
      chk("t4_wait", 32'(w), 32'h0);
      chk("t4_no_valid1", 32'(bus.out_valid[1]), 32'h0);
    end
    step();
    chk("t4_drop", 32'(drop_cnt), 32'(exp_drop));
    chk("t4_drop_const", 32'(drop_cnt), 32'h3);
    out_en = 4'hF;

    // counter saturation
    for (int k = 0; k < 300; k++) send(2'd0, 8'(k), w);
    step(); step();
    chk("t5_deliv0_sat", 32'(deliv_cnt[0]), 32'hFF);
    chk("t5_deliv1", 32'(deliv_cnt[1]), 32'h3);
    chk("t5_deliv2", 32'(deliv_cnt[2]), 32'h1);
    chk("t5_deliv3", 32'(deliv_cnt[3]), 32'h2);

    // reset with full, stalled slots
    bus.out_ready = 4'h0;
    send(2'd0, 8'h50, w);
    send(2'd2, 8'h52, w);
    chk("t6_full", 32'(bus.out_valid), 32'h5);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_sel = 2'd3; bus.in_data = 8'hEE;
    step();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    exp_drop = 0;
    chk("t6_valid_clr", 32'(bus.out_valid), 32'h0);
    chk("t6_data_clr", 32'(bus.out_data), 32'h0);
    chk("t6_deliv_clr", 32'(deliv_cnt), 32'h0);
    chk("t6_drop_clr", 32'(drop_cnt), 32'h0);
    chk("t6_in_ready_rst", 32'(bus.in_ready), 32'h1);
    step();
    chk("t6_no_capture", 32'(bus.out_valid), 32'h0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    bus.out_ready = 4'hF;
    step();
    send(2'd3, 8'h77, w);
    chk("t6_post_valid", 32'(bus.out_valid), 32'h8);
    chk("t6_post_data", 32'(bus.out_data[3]), 32'h77);
    step();
    chk("t6_post_deliv3", 32'(deliv_cnt[3]), 32'h1);
    chk("t6_post_drop", 32'(drop_cnt), 32'h0);

    step(); step();
    for (int i = 0; i < 4; i++)
      chk($sformatf("q_empty[%0d]", i), 32'(exp_q[i].size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
